// File: rtl/spi_adc_responder.sv
// ADC78H90 emulator: an AXI4-Lite writable bank of eight 12-bit channels served to an SPI master.
// Optional macro SPI_ADC_RESPONDER_AUTOINC_EN adds a per-channel increment after each completed frame.
module spi_adc_responder #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      nCS,
  input  logic                      SCLK,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, mosi_sync_q;
  logic ncs_prev_q, sclk_prev_q;
  logic ncs_s, sclk_s, mosi_s;
  logic ncs_fall_s, ncs_rise_s, sclk_fall_s, sclk_rise_s;

  state_e state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  rise_q, rise_d;
  logic [2:0]  cur_q, cur_d, next_addr_q, next_addr_d;
  logic        miso_q, miso_d;
  logic        frame_done_s;

  logic [7:0][11:0] ch_q, ch_d;

  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [2:0]  awaddr_q, awaddr_d;
  logic [11:0] wdata_q, wdata_d;
  logic        aw_hs_s, w_hs_s, wr_en_s;
  logic [2:0]  wr_addr_s;
  logic [11:0] wr_data_s;

`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
  logic [7:0] inc_q, inc_d;
  logic       winc_q, winc_d, wr_inc_s;
`endif

  logic unused_s;
  assign unused_s = ^{s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_arvalid, s_axi_rready};

  // Bring the master's asynchronous pins into the aclk domain and keep one-cycle-old copies for edge detection.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ncs_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ncs_prev_q  <= ncs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_fall_s  = ncs_prev_q & ~ncs_s;
  assign ncs_rise_s  = ~ncs_prev_q & ncs_s;
  assign sclk_fall_s = sclk_prev_q & ~sclk_s;
  assign sclk_rise_s = ~sclk_prev_q & sclk_s;

  // Frame FSM: snapshot on nCS fall, shift on SCLK falls, capture the next address on rises 3..5.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    rise_d       = rise_q;
    cur_d        = cur_q;
    next_addr_d  = next_addr_q;
    miso_d       = miso_q;
    frame_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ncs_fall_s) begin
          state_d = ST_SHIFT;
          shift_d = {4'b0000, ch_q[cur_q]};
          rise_d  = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise_s) begin
          rise_d = rise_q + 5'd1;
          case (rise_d)
            5'd3:    next_addr_d[2] = mosi_s;
            5'd4:    next_addr_d[1] = mosi_s;
            5'd5:    next_addr_d[0] = mosi_s;
            default: next_addr_d    = next_addr_q;
          endcase
          if (rise_d == 5'd16) begin
            state_d      = ST_DONE;
            frame_done_s = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (sclk_fall_s && (rise_q >= 5'd1) && (rise_q < 5'd16)) begin
          shift_d = {shift_q[14:0], 1'b0};
          miso_d  = shift_q[14];
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (ncs_rise_s) begin
          state_d = ST_IDLE;
          cur_d   = next_addr_q;
          miso_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  // Frame state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      shift_q     <= 16'h0000;
      rise_q      <= 5'd0;
      cur_q       <= 3'd0;
      next_addr_q <= 3'd0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rise_q      <= rise_d;
      cur_q       <= cur_d;
      next_addr_q <= next_addr_d;
      miso_q      <= miso_d;
    end
  end

  // AXI write path: AW and W latch independently, the write commits as soon as both are available.
  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wr_en_s   = 1'b0;
    aw_hs_s   = s_axi_awvalid & awready_q;
    w_hs_s    = s_axi_wvalid & wready_q;
    wr_addr_s = aw_full_q ? awaddr_q : s_axi_awaddr[4:2];
    wr_data_s = w_full_q ? wdata_q : s_axi_wdata[11:0];
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
    winc_d   = winc_q;
    wr_inc_s = w_full_q ? winc_q : s_axi_wdata[31];
`endif
    if (aw_hs_s) begin
      awready_d = 1'b0;
      aw_full_d = 1'b1;
      awaddr_d  = s_axi_awaddr[4:2];
    end else begin
      awaddr_d = awaddr_q;
    end
    if (w_hs_s) begin
      wready_d = 1'b0;
      w_full_d = 1'b1;
      wdata_d  = s_axi_wdata[11:0];
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
      winc_d   = s_axi_wdata[31];
`endif
    end else begin
      wdata_d = wdata_q;
    end
    if ((aw_full_q | aw_hs_s) && (w_full_q | w_hs_s)) begin
      wr_en_s   = 1'b1;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (bvalid_q && s_axi_bready) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end else begin
      bvalid_d = bvalid_d;
    end
  end

  // Channel bank next state; an AXI write overrides a same-cycle increment.
  always_comb begin
    ch_d = ch_q;
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
    inc_d = inc_q;
    if (frame_done_s && inc_q[cur_q]) begin
      ch_d[cur_q] = ch_q[cur_q] + 12'd1;
    end else begin
      ch_d[cur_q] = ch_q[cur_q];
    end
    if (wr_en_s) begin
      inc_d[wr_addr_s] = wr_inc_s;
    end else begin
      inc_d = inc_q;
    end
`endif
    if (wr_en_s) begin
      ch_d[wr_addr_s] = wr_data_s;
    end else begin
      ch_d = ch_d;
    end
  end

  // AXI and channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= 3'd0;
      wdata_q   <= 12'h000;
      ch_q      <= '0;
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
      inc_q     <= 8'h00;
      winc_q    <= 1'b0;
`endif
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      ch_q      <= ch_d;
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
      inc_q     <= inc_d;
      winc_q    <= winc_d;
`endif
    end
  end

  assign MISO          = miso_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = 1'b0;
  assign s_axi_rdata   = '0;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = 1'b0;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a CPOL=1 SPI master model plus AXI write tasks.
module tb_spi_adc_responder;

  localparam int HALF = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        nCS = 1'b1, SCLK = 1'b1, MOSI = 1'b0, MISO;
  logic [15:0] awaddr = 16'h0000, araddr = 16'h0000;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [31:0] wdata = 32'h0, rdata;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  spi_adc_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge aclk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {bvalid, awready, wready}, 3'b100);
    @(negedge aclk);
    chk("wr_bdone", {bvalid, awready, wready}, 3'b011);
  endtask

  task automatic spi_frame(input logic [2:0] a, input int nrise, output logic [15:0] word);
    logic [15:0] ctrl;
    ctrl = {2'b00, a, 11'b0};
    word = 16'h0000;
    @(negedge aclk);
    nCS = 1'b0;
    repeat (HALF) @(negedge aclk);
    for (int k = 0; k < nrise; k++) begin
      SCLK = 1'b0;
      MOSI = ctrl[15-k];
      repeat (HALF) @(negedge aclk);
      word = {word[14:0], MISO};
      SCLK = 1'b1;
      repeat (HALF) @(negedge aclk);
    end
    nCS = 1'b1;
    repeat (HALF) @(negedge aclk);
  endtask

  logic [15:0] w;

  initial begin
    vecs[0] = '{3'd2, 16'h00F0};
    vecs[1] = '{3'd3, 16'h0ABC};
    vecs[2] = '{3'd7, 16'h0123};
    vecs[3] = '{3'd6, 16'h0FFF};
    vecs[4] = '{3'd4, 16'h0666};
    vecs[5] = '{3'd1, 16'h0800};
    vecs[6] = '{3'd1, 16'h0055};
    vecs[7] = '{3'd0, 16'h0055};

    repeat (4) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("rst_miso", MISO, 1'b0);
    chk("rst_axi", {awready, wready, bvalid, bresp}, 5'b11000);
    chk("rst_rd", {arready, rvalid, rresp, rdata}, 36'h0);

    // Pipelined select: first frame after reset returns CH0 regardless of the address sent.
    axi_write(16'h0014, 32'h0000_05A5);
    spi_frame(3'd5, 16, w);
    chk("post_rst_ch0", w, 16'h0000);
    spi_frame(3'd0, 16, w);
    chk("second_ch5", w, 16'h05A5);
    chk("idle_miso", MISO, 1'b0);

    axi_write(16'h0000, 32'h0000_00F0);
    axi_write(16'h0004, 32'h0000_0055);
    axi_write(16'h0008, 32'h0000_0ABC);
    axi_write(16'h000C, 32'h0000_0123);
    axi_write(16'h0010, 32'h0000_0800);
    axi_write(16'h0018, 32'h7FFF_F666);
    axi_write(16'hFF1C, 32'h0000_0FFF);
    for (int i = 0; i < 8; i++) begin
      spi_frame(vecs[i].addr, 16, w);
      chk($sformatf("vec%0d", i), w, {16'h0, vecs[i].exp});
    end

    // Abort after 7 rises carrying address 6: current channel stays 0.
    spi_frame(3'd6, 7, w);
    chk("abort_miso", MISO, 1'b0);
    spi_frame(3'd2, 16, w);
    chk("after_abort", w, 16'h00F0);

    // Write CH1 while a CH1 frame is in flight.
    spi_frame(3'd1, 16, w);
    chk("sel_ch1", w, 16'h0ABC);
    fork
      spi_frame(3'd1, 16, w);
      begin
        repeat (40) @(negedge aclk);
        axi_write(16'hF004, 32'h0000_0FFF);
      end
    join
    chk("inflight_old", w, 16'h0055);

    // AW three cycles ahead of W, bready low for five bvalid cycles.
    @(negedge aclk);
    awaddr = 16'h000C; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0; wdata = 32'h0;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("aw_drop", {awready, wready, bvalid}, 3'b010);
    @(negedge aclk);
    @(negedge aclk);
    wvalid = 1'b1; wdata = 32'h0000_0321;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("w_drop", wready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b_hold%0d", i), {bvalid, awready, bresp}, 4'b1000);
      if (i == 4) bready = 1'b1;
      @(negedge aclk);
    end
    chk("b_release", {bvalid, awready, wready}, 3'b011);

    axi_write(16'h0010, 32'h8000_0FFE);
    spi_frame(3'd3, 16, w);
    chk("next_ch1_new", w, 16'h0FFF);
    spi_frame(3'd4, 16, w);
    chk("ch3_single_wr", w, 16'h0321);
    spi_frame(3'd4, 16, w);
    chk("ch4_f1", w, 16'h0FFE);
    spi_frame(3'd4, 16, w);
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
    chk("ch4_f2", w, 16'h0FFF);
`else
    chk("ch4_f2", w, 16'h0FFE);
`endif
    spi_frame(3'd4, 16, w);
`ifdef SPI_ADC_RESPONDER_AUTOINC_EN
    chk("ch4_f3_wrap", w, 16'h0000);
`else
    chk("ch4_f3", w, 16'h0FFE);
`endif

    // Asynchronous reset mid-frame while MISO is driving a 1.
    axi_write(16'h0010, 32'h0000_0FFF);
    @(negedge aclk);
    nCS = 1'b0;
    repeat (HALF) @(negedge aclk);
    for (int k = 0; k < 6; k++) begin
      SCLK = 1'b0;
      repeat (HALF) @(negedge aclk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge aclk);
    end
    SCLK = 1'b0;
    repeat (HALF) @(negedge aclk);
    chk("pre_rst_miso", MISO, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("async_rst_miso", MISO, 1'b0);
    nCS = 1'b1; SCLK = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    chk("rst2_axi", {awready, wready, bvalid}, 3'b110);
    spi_frame(3'd0, 16, w);
    chk("rst2_ch0", w, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
